// File: rtl/cache_block_fill_evict_fsm_if.sv
// Memory-side request/response port of the block fill/evict engine.
// Zero latency of its own; requests are valid/ready, read responses are valid-only and in order.
// Master holds mem_req and its payload until mem_req_ready; responses cannot be stalled.
interface cache_block_fill_evict_fsm_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic              mem_req_we;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_rd_valid;
    logic [DATA_W-1:0] mem_rd_data;

    modport master (
        output mem_req, mem_req_we, mem_address, mem_wr_data,
        input  mem_req_ready, mem_rd_valid, mem_rd_data
    );

    modport slave (
        input  mem_req, mem_req_we, mem_address, mem_wr_data,
        output mem_req_ready, mem_rd_valid, mem_rd_data
    );
endinterface

// File: rtl/cache_block_fill_evict_fsm.sv
// Miss handler: optional dirty-victim write-back, pipelined block refill, then tag/valid update.
// Latency: WORDS + L + 1 cycles from miss to the tag write (clean victim, no stalls, memory latency L).
// Backpressure: a request is held stable until mem_req_ready; read responses are always accepted.
// Ports: clk/rst_n; miss/victim info from the tag logic; victim_rd_data from the data array;
// mem (interface master) toward the memory arbiter; fsm_busy stalls the pipeline;
// cache_word_idx/cache_wr_data/write_* drive the data, tag and valid arrays.
module cache_block_fill_evict_fsm #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int WORDS    = 8,
    parameter int BYTE_OFF = 1,
    parameter bit WB_EN    = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       miss_detected,
    input  logic [ADDR_W-1:0]          miss_address,
    input  logic                       victim_dirty,
    input  logic [ADDR_W-1:0]          victim_address,
    input  logic [DATA_W-1:0]          victim_rd_data,
    cache_block_fill_evict_fsm_if.master mem,
    output logic                       fsm_busy,
    output logic [$clog2(WORDS)-1:0]   cache_word_idx,
    output logic [DATA_W-1:0]          cache_wr_data,
    output logic                       write_data_array,
    output logic                       write_tag_array,
    output logic                       write_valid_bit
);
    localparam int IDX_W = $clog2(WORDS);
    localparam int CNT_W = IDX_W + 1;
    localparam int OFF_W = IDX_W + BYTE_OFF;
    localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'((1 << OFF_W) - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WORDS - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  miss_base_q, miss_base_d;
    logic [ADDR_W-1:0]  victim_base_q, victim_base_d;
    logic [CNT_W-1:0]   wb_cnt_q, wb_cnt_d;
    logic [CNT_W-1:0]   iss_cnt_q, iss_cnt_d;
    logic [CNT_W-1:0]   rcv_cnt_q, rcv_cnt_d;

    logic               req, req_we;
    logic [ADDR_W-1:0]  req_addr;
    logic [DATA_W-1:0]  req_wdat;

    // Base has its offset bits cleared, so OR-ing in the word offset stays inside the block.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [CNT_W-1:0]  cnt);
        return base | (ADDR_W'(cnt[IDX_W-1:0]) << BYTE_OFF);
    endfunction

    always_comb begin
        state_d          = state_q;
        miss_base_d      = miss_base_q;
        victim_base_d    = victim_base_q;
        wb_cnt_d         = wb_cnt_q;
        iss_cnt_d        = iss_cnt_q;
        rcv_cnt_d        = rcv_cnt_q;
        req              = 1'b0;
        req_we           = 1'b0;
        req_addr         = '0;
        req_wdat         = '0;
        fsm_busy         = 1'b0;
        cache_word_idx   = '0;
        cache_wr_data    = '0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        write_valid_bit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Gated by rst_n so every output reads 0 while reset is held.
                fsm_busy = miss_detected & rst_n;
                if (miss_detected) begin
                    miss_base_d   = miss_address & BLK_MASK;
                    victim_base_d = victim_address & BLK_MASK;
                    wb_cnt_d      = '0;
                    iss_cnt_d     = '0;
                    rcv_cnt_d     = '0;
                    state_d       = (WB_EN && victim_dirty) ? S_WB : S_FILL;
                end
            end
            S_WB: begin
                fsm_busy       = 1'b1;
                req            = 1'b1;
                req_we         = 1'b1;
                req_addr       = word_addr(victim_base_q, wb_cnt_q);
                req_wdat       = victim_rd_data;
                cache_word_idx = wb_cnt_q[IDX_W-1:0];
                if (mem.mem_req_ready) begin
                    wb_cnt_d = wb_cnt_q + CNT_W'(1);
                    if (wb_cnt_q == CNT_LAST) begin
                        iss_cnt_d = '0;
                        rcv_cnt_d = '0;
                        state_d   = S_FILL;
                    end
                end
            end
            S_FILL: begin
                fsm_busy       = 1'b1;
                cache_word_idx = rcv_cnt_q[IDX_W-1:0];
                // Issue and collection run independently; both may fire in one cycle.
                if (iss_cnt_q < CNT_FULL) begin
                    req      = 1'b1;
                    req_addr = word_addr(miss_base_q, iss_cnt_q);
                    if (mem.mem_req_ready) iss_cnt_d = iss_cnt_q + CNT_W'(1);
                end
                if (mem.mem_rd_valid) begin
                    write_data_array = 1'b1;
                    cache_wr_data    = mem.mem_rd_data;
                    rcv_cnt_d        = rcv_cnt_q + CNT_W'(1);
                    if (rcv_cnt_q == CNT_LAST) state_d = S_DONE;
                end
            end
            S_DONE: begin
                fsm_busy        = 1'b1;
                write_tag_array = 1'b1;
                write_valid_bit = 1'b1;
                state_d         = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem.mem_req     = req;
    assign mem.mem_req_we  = req_we;
    assign mem.mem_address = req_addr;
    assign mem.mem_wr_data = req_wdat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            miss_base_q   <= '0;
            victim_base_q <= '0;
            wb_cnt_q      <= '0;
            iss_cnt_q     <= '0;
            rcv_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            miss_base_q   <= miss_base_d;
            victim_base_q <= victim_base_d;
            wb_cnt_q      <= wb_cnt_d;
            iss_cnt_q     <= iss_cnt_d;
            rcv_cnt_q     <= rcv_cnt_d;
        end
    end
endmodule

// File: tb/tb_cache_block_fill_evict_fsm.sv
module tb_cache_block_fill_evict_fsm;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, sel, miss, vdirty, rdy, rvld, seq_mode;
    logic [15:0] maddr, vaddr;
    logic [31:0] rdat, mseed, vseed;
    int          total, bad, last_acc, first_wr;

    typedef struct { logic we; logic [15:0] addr; logic [31:0] dat; } req_t;
    typedef struct { int due; logic [31:0] dat; } rsp_t;

    // Victim block contents as seen through the data-array read port.
    function automatic logic [31:0] vfn(input int i, input logic [31:0] seed);
        return (32'hC0DE0000 + 32'(i) * 32'h01010101) ^ seed;
    endfunction

    // Memory contents by address; sequence mode gives 0x1111*(word+1).
    function automatic logic [31:0] memfn(input logic [15:0] a, input int w, input int bo,
                                          input logic sq, input logic [31:0] seed);
        if (sq) return 32'h1111 * (((32'(a) >> bo) & 32'(w - 1)) + 1);
        return {a, ~a} ^ seed;
    endfunction

    cache_block_fill_evict_fsm_if #(.ADDR_W(16), .DATA_W(16)) if_a ();
    cache_block_fill_evict_fsm_if #(.ADDR_W(16), .DATA_W(32)) if_b ();

    assign if_a.mem_req_ready = rdy;
    assign if_a.mem_rd_valid  = rvld & ~sel;
    assign if_a.mem_rd_data   = rdat[15:0];
    assign if_b.mem_req_ready = rdy;
    assign if_b.mem_rd_valid  = rvld & sel;
    assign if_b.mem_rd_data   = rdat;

    logic        a_busy, a_wda, a_tag, a_vb, b_busy, b_wda, b_tag, b_vb;
    logic [2:0]  a_idx;
    logic [1:0]  b_idx;
    logic [15:0] a_cwd, a_vrd;
    logic [31:0] a_vfull, b_cwd, b_vrd;
    assign a_vfull = vfn(int'(a_idx), vseed);
    assign a_vrd   = a_vfull[15:0];
    assign b_vrd   = vfn(int'(b_idx), vseed);

    cache_block_fill_evict_fsm #(.ADDR_W(16), .DATA_W(16), .WORDS(8), .BYTE_OFF(1), .WB_EN(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .miss_detected(miss & ~sel), .miss_address(maddr),
        .victim_dirty(vdirty), .victim_address(vaddr), .victim_rd_data(a_vrd), .mem(if_a),
        .fsm_busy(a_busy), .cache_word_idx(a_idx), .cache_wr_data(a_cwd),
        .write_data_array(a_wda), .write_tag_array(a_tag), .write_valid_bit(a_vb));

    cache_block_fill_evict_fsm #(.ADDR_W(16), .DATA_W(32), .WORDS(4), .BYTE_OFF(2), .WB_EN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .miss_detected(miss & sel), .miss_address(maddr),
        .victim_dirty(vdirty), .victim_address(vaddr), .victim_rd_data(b_vrd), .mem(if_b),
        .fsm_busy(b_busy), .cache_word_idx(b_idx), .cache_wr_data(b_cwd),
        .write_data_array(b_wda), .write_tag_array(b_tag), .write_valid_bit(b_vb));

    // Observation view of whichever instance is selected.
    logic        o_req, o_we, o_busy, o_wda, o_tag, o_vb;
    logic [15:0] o_addr;
    logic [31:0] o_wdat, o_cwd;
    logic [2:0]  o_idx;
    assign o_req  = sel ? if_b.mem_req     : if_a.mem_req;
    assign o_we   = sel ? if_b.mem_req_we  : if_a.mem_req_we;
    assign o_addr = sel ? if_b.mem_address : if_a.mem_address;
    assign o_wdat = sel ? if_b.mem_wr_data : {16'h0, if_a.mem_wr_data};
    assign o_busy = sel ? b_busy : a_busy;
    assign o_wda  = sel ? b_wda  : a_wda;
    assign o_tag  = sel ? b_tag  : a_tag;
    assign o_vb   = sel ? b_vb   : a_vb;
    assign o_idx  = sel ? {1'b0, b_idx} : a_idx;
    assign o_cwd  = sel ? b_cwd  : {16'h0, a_cwd};

    function automatic logic pick_rdy(input int mode, input logic cur);
        if (mode == 0) return 1'b1;
        if (mode == 1) return ~cur;
        return ($urandom_range(0, 3) != 0);
    endfunction

    // One miss from the IDLE cycle through the first IDLE cycle after DONE.
    // Called and returns just after a rising edge. rst_after>=0 resets after that many array writes.
    task automatic run_txn(input string nm, input int w, input int bo, input logic wben,
                           input logic dirty, input logic [15:0] ma, input logic [15:0] va,
                           input int lat, input int rmode, input logic stray,
                           input int rst_after, input int exp_busy);
        req_t        exp_q[$];
        rsp_t        rq[$];
        logic [31:0] exp_wr[$];
        logic [15:0] mb, vb, hold_addr;
        logic [31:0] dmask, hold_dat;
        logic        hold, hold_we, from_q, done, wb_mode;
        int          nacc, nwr, ntag, nbusy, nwb;
        mb    = ma & ~16'((w << bo) - 1);
        vb    = va & ~16'((w << bo) - 1);
        dmask = sel ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        wb_mode = wben && dirty;
        nwb   = wb_mode ? w : 0;
        for (int i = 0; i < nwb; i++) exp_q.push_back('{1'b1, vb + 16'(i << bo), vfn(i, vseed) & dmask});
        for (int i = 0; i < w; i++) begin
            exp_q.push_back('{1'b0, mb + 16'(i << bo), 32'h0});
            exp_wr.push_back(memfn(mb + 16'(i << bo), w, bo, seq_mode, mseed) & dmask);
        end
        nacc = 0; nwr = 0; ntag = 0; nbusy = 0; hold = 0; done = 0; from_q = 0;
        hold_addr = '0; hold_dat = '0; hold_we = 0;
        miss = 1'b1; maddr = ma; vaddr = va; vdirty = dirty;
        rdy  = pick_rdy(rmode, 1'b0);
        rvld = stray; rdat = 32'hDEAD_BEEF;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (o_busy) nbusy++;
            if (hold) begin
                total++;
                if (!o_req || o_addr !== hold_addr || o_we !== hold_we || (hold_we && o_wdat !== hold_dat)) begin
                    bad++;
                    $display("FAIL %s hold c%0d: got req=%0b we=%0b addr=%h dat=%h want req=1 we=%0b addr=%h dat=%h",
                             nm, c, o_req, o_we, o_addr, o_wdat, hold_we, hold_addr, hold_dat);
                end
            end
            hold = 0;
            if (o_req && rdy) begin
                total++;
                if (nacc >= exp_q.size()) begin
                    bad++;
                    $display("FAIL %s extra_req: got addr=%h we=%0b want none", nm, o_addr, o_we);
                end else if (o_we !== exp_q[nacc].we || o_addr !== exp_q[nacc].addr ||
                             (o_we && o_wdat !== exp_q[nacc].dat)) begin
                    bad++;
                    $display("FAIL %s req%0d: got we=%0b addr=%h dat=%h want we=%0b addr=%h dat=%h", nm, nacc,
                             o_we, o_addr, o_wdat, exp_q[nacc].we, exp_q[nacc].addr, exp_q[nacc].dat);
                end
                if (!o_we) rq.push_back('{c + lat, memfn(o_addr, w, bo, seq_mode, mseed)});
                nacc++; last_acc = c;
            end else if (o_req) begin
                hold = 1; hold_addr = o_addr; hold_we = o_we; hold_dat = o_wdat;
            end
            if (o_wda) begin
                total++;
                if (nwr >= w) begin
                    bad++;
                    $display("FAIL %s extra_wr: got idx=%0d dat=%h want none", nm, o_idx, o_cwd);
                end else if (o_idx !== 3'(nwr) || o_cwd !== exp_wr[nwr]) begin
                    bad++;
                    $display("FAIL %s wr%0d: got idx=%0d dat=%h want idx=%0d dat=%h", nm, nwr, o_idx, o_cwd, nwr, exp_wr[nwr]);
                end
                if (nwr == 0) first_wr = c;
                nwr++;
            end
            if (from_q) void'(rq.pop_front());
            if (o_tag) begin
                total++; ntag++; done = 1;
                if (!o_vb || o_idx !== 3'd0 || nwr != w) begin
                    bad++;
                    $display("FAIL %s tag: got vb=%0b idx=%0d writes=%0d want vb=1 idx=0 writes=%0d", nm, o_vb, o_idx, nwr, w);
                end
            end
            if (rst_after >= 0 && nwr == rst_after && !done) begin
                #1 rst_n = 1'b0; miss = 1'b1; rvld = 1'b0;
                #1 total++;
                if (o_req || o_wda || o_tag || o_vb || o_busy || o_idx !== 3'd0) begin
                    bad++;
                    $display("FAIL %s in_reset: got req=%0b wda=%0b tag=%0b vb=%0b busy=%0b idx=%0d want all 0",
                             nm, o_req, o_wda, o_tag, o_vb, o_busy, o_idx);
                end
                @(posedge clk); #1 total++;
                if (o_req || o_wda || o_tag || o_busy) begin
                    bad++;
                    $display("FAIL %s held_reset: got req=%0b wda=%0b tag=%0b busy=%0b want 0", nm, o_req, o_wda, o_tag, o_busy);
                end
                @(negedge clk); miss = 1'b0; rst_n = 1'b1;
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
            miss = 1'b0;
            if (done) break;
            rdy = pick_rdy(rmode, rdy);
            from_q = 0;
            if (rq.size() > 0 && rq[0].due <= c + 1) begin
                rvld = 1'b1; rdat = rq[0].dat; from_q = 1;
            end else if (stray && wb_mode && nacc < w) begin
                rvld = 1'b1; rdat = 32'hBAD0_0BAD;   // stray response while writing back
            end else begin
                rvld = 1'b0;
            end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL %s timeout: got writes=%0d reqs=%0d want done", nm, nwr, nacc);
        end
        rvld = stray; rdat = 32'h5555_AAAA;          // stray response in IDLE
        @(negedge clk);
        total++;
        if (o_busy || o_wda || o_req || o_tag) begin
            bad++;
            $display("FAIL %s idle_after: got busy=%0b wda=%0b req=%0b tag=%0b want 0", nm, o_busy, o_wda, o_req, o_tag);
        end
        @(posedge clk); #1 rvld = 1'b0;
        total++;
        if (nacc != exp_q.size() || nwr != w || ntag != 1) begin
            bad++;
            $display("FAIL %s counts: got reqs=%0d writes=%0d tags=%0d want %0d %0d 1", nm, nacc, nwr, ntag, exp_q.size(), w);
        end
        if (exp_busy >= 0) begin
            total++;
            if (nbusy != exp_busy) begin
                bad++;
                $display("FAIL %s busy_cycles: got %0d want %0d", nm, nbusy, exp_busy);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sel = 0; miss = 0; vdirty = 0; rdy = 0; rvld = 0; rdat = '0;
        maddr = '0; vaddr = '0; seq_mode = 0; mseed = '0; vseed = '0;
        repeat (2) @(posedge clk);
        #1 miss = 1'b1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1 total++;
            if (o_req || o_busy || o_wda || o_tag || o_vb || o_idx !== 3'd0 || o_cwd !== 32'h0) begin
                bad++;
                $display("FAIL reset_state sel%0d: got req=%0b busy=%0b wda=%0b tag=%0b vb=%0b idx=%0d want all 0",
                         s, o_req, o_busy, o_wda, o_tag, o_vb, o_idx);
            end
        end
        miss = 1'b0; sel = 0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1 miss = 1'b1;
        #1 total++;
        if (o_busy !== 1'b1) begin bad++; $display("FAIL idle_busy_follows_miss: got %0b want 1", o_busy); end
        miss = 1'b0;
        #1 total++;
        if (o_busy !== 1'b0) begin bad++; $display("FAIL idle_busy_no_miss: got %0b want 0", o_busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_clean_fill();
        seq_mode = 1;
        run_txn("clean_fill", 8, 1, 1, 0, 16'h1234, 16'h0000, 4, 0, 0, -1, 14);
        seq_mode = 0;
    endtask

    task automatic test_dirty_evict();
        vseed = $urandom; mseed = $urandom;
        run_txn("dirty_evict", 8, 1, 1, 1, 16'h1234, 16'h5678, 3, 0, 1, -1, -1);
    endtask

    task automatic test_backpressure();
        mseed = $urandom;
        run_txn("backpressure", 8, 1, 1, 1, 16'h1234, 16'h5678, 2, 1, 0, -1, -1);
    endtask

    task automatic test_overlap_stray();
        mseed = $urandom;
        run_txn("overlap", 8, 1, 1, 0, 16'h1234, 16'h0000, 7, 0, 1, -1, 17);
        total++;
        if (first_wr != last_acc) begin
            bad++;
            $display("FAIL overlap_cycle: got first_wr=%0d last_accept=%0d want equal", first_wr, last_acc);
        end
    endtask

    task automatic test_reset_mid_fill();
        mseed = $urandom;
        run_txn("mid_reset", 8, 1, 1, 0, 16'h1234, 16'h0000, 3, 0, 0, 3, -1);
        run_txn("after_reset", 8, 1, 1, 0, 16'h1234, 16'h0000, 3, 0, 0, -1, 13);
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            mseed = $urandom; vseed = $urandom;
            run_txn("random", 8, 1, 1, 1'($urandom), 16'($urandom), 16'($urandom),
                    $urandom_range(1, 6), 2, 1'($urandom), -1, -1);
        end
    endtask

    task automatic test_param_words4();
        sel = 1'b1;
        seq_mode = 1;
        run_txn("words4", 4, 2, 0, 1, 16'h00AC, 16'h7777, 2, 0, 1, -1, 8);
        seq_mode = 0;
        for (int k = 0; k < 4; k++) begin
            mseed = $urandom;
            run_txn("words4_rand", 4, 2, 0, 1'($urandom), 16'($urandom), 16'($urandom),
                    $urandom_range(1, 5), 2, 0, -1, -1);
        end
        sel = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0; last_acc = -1; first_wr = -2;
        test_reset();
        test_clean_fill();
        test_dirty_evict();
        test_backpressure();
        test_overlap_stray();
        test_reset_mid_fill();
        test_random();
        test_param_words4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end
endmodule
